// File: rtl/event_stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// event_stopwatch_pkg
// Shared constants for the stopwatch and its companion countdown timer:
// state encodings and the default count width.
// -----------------------------------------------------------------------------
package event_stopwatch_pkg;

  // State encodings, shared with the countdown timer's tooling.
  localparam logic [1:0] SW_IDLE     = 2'd0;
  localparam logic [1:0] SW_COUNTING = 2'd1;
  localparam logic [1:0] SW_DONE     = 2'd2;

  // Default width of the elapsed-cycle count.
  localparam int SW_ISIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = SW_IDLE,
    ST_COUNTING = SW_COUNTING,
    ST_DONE     = SW_DONE
  } sw_state_e;

endpackage

// File: rtl/event_stopwatch_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// One-bit rising-edge detector. Registers the input every cycle and flags a
// 0 -> 1 transition between the previous and the current sample.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; previous sample clears to 0
//   in    : level input
//   rise  : in & !in_q (combinational from the live input)
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q_r;

  // Previous-sample register, updated unconditionally every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q_r <= 1'b0;
    end else begin
      in_q_r <= in;
    end
  end

  assign rise = in & ~in_q_r;

endmodule

// File: rtl/event_stopwatch.sv
// -----------------------------------------------------------------------------
// event_stopwatch
// Measures the number of clock cycles between a sampled start request and the
// next rising edge on stop, then offers the result on a valid/ready handshake.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high
//   start    : level-sampled; begins or restarts a measurement
//   stop     : event input; only its rising edge is significant
//   ready    : consumer accepts the result
//   elapsed  : measured cycle count, saturating at all-ones
//   overflow : measurement saturated (qualified by valid)
//   valid    : result available
//   busy     : measurement in progress
// -----------------------------------------------------------------------------
module event_stopwatch
  import event_stopwatch_pkg::*;
#(
  parameter int ISIZE = SW_ISIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ready,
  output logic [ISIZE-1:0] elapsed,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  localparam logic [ISIZE-1:0] CNT_MAX  = {ISIZE{1'b1}};
  localparam logic [ISIZE-1:0] CNT_ZERO = {ISIZE{1'b0}};
  localparam logic [ISIZE-1:0] CNT_ONE  = ISIZE'(1'b1);

  sw_state_e        state_r;
  logic [ISIZE-1:0] count_r;
  logic             stop_rise_s;
  logic             count_at_max_s;
  logic [ISIZE-1:0] count_inc_s;

  // The edge register runs in every state, so a stop level that is already
  // high when counting begins never looks like an edge.
  rise_detect u_stop_edge (
    .clk   (clk),
    .reset (reset),
    .in    (stop),
    .rise  (stop_rise_s)
  );

  // Saturating increment. The counter holds (N-1) just before the stop edge
  // is sampled, so the captured value is this incremented count; a counter
  // already at all-ones means N exceeds the representable range.
  always_comb begin
    count_at_max_s = (count_r == CNT_MAX);
    if (count_at_max_s) begin
      count_inc_s = CNT_MAX;
    end else begin
      count_inc_s = count_r + CNT_ONE;
    end
  end

  // Measurement FSM with registered result and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      elapsed  <= CNT_ZERO;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A stop edge coinciding with start is discarded: start wins.
          if (start) begin
            state_r <= ST_COUNTING;
            count_r <= CNT_ZERO;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_COUNTING: begin
          // Stop takes priority over a simultaneous restart request.
          if (stop_rise_s) begin
            state_r  <= ST_DONE;
            elapsed  <= count_inc_s;
            overflow <= count_at_max_s;
            valid    <= 1'b1;
            busy     <= 1'b0;
          end else if (start) begin
            count_r <= CNT_ZERO;
          end else begin
            count_r <= count_inc_s;
          end
        end
        ST_DONE: begin
          // start/stop are ignored here; result holds until accepted.
          if (ready) begin
            state_r <= ST_IDLE;
            valid   <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= CNT_ZERO;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_event_stopwatch
// Self-checking bench for event_stopwatch (ISIZE=4 so saturation is reachable).
// A transaction-level reference model predicts outputs from cycle timestamps;
// a constant table covers the basic measurement and hand sequences cover the
// multi-cycle corner cases, followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_event_stopwatch;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         ready;
  logic [W-1:0] elapsed;
  logic         overflow;
  logic         valid;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 measuring, 2 result pending.
  int m_mode;
  int m_t0;
  int cyc;
  bit m_prev;
  int m_el;
  bit m_ov;

  event_stopwatch #(.ISIZE(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .ready    (ready),
    .elapsed  (elapsed),
    .overflow (overflow),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_prev = 1'b0;
    m_el   = 0;
    m_ov   = 1'b0;
  endtask

  // Advance the model by one sampled edge.
  task automatic model_edge(input bit s, input bit p, input bit r);
    bit rise;
    int n;
    rise   = p && !m_prev;
    m_prev = p;
    if (m_mode == 0) begin
      if (s) begin
        m_mode = 1;
        m_t0   = cyc;
      end
    end else if (m_mode == 1) begin
      if (rise) begin
        n      = cyc - m_t0;
        m_el   = (n > MAX) ? MAX : n;
        m_ov   = (n > MAX);
        m_mode = 2;
      end else if (s) begin
        m_t0 = cyc;
      end
    end else begin
      if (r) m_mode = 0;
    end
    cyc++;
  endtask

  task automatic check_model();
    chk("model_valid",    valid,    (m_mode == 2) ? 1 : 0);
    chk("model_busy",     busy,     (m_mode == 1) ? 1 : 0);
    chk("model_elapsed",  elapsed,  m_el);
    chk("model_overflow", overflow, m_ov);
  endtask

  // Drive inputs away from the edge, clock once, then compare.
  task automatic cycle(input bit s, input bit p, input bit r);
    start = s;
    stop  = p;
    ready = r;
    @(posedge clk);
    model_edge(s, p, r);
    #1;
    check_model();
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_valid"},    valid,    0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_elapsed"},  elapsed,  0);
    chk({tag, "_overflow"}, overflow, 0);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit s;
    bit p;
    bit r;
    bit ev;
    bit eb;
    int eel;
    bit eov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Basic measurement: start, stop edge 5 edges later, ready held high.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0};

    cyc   = 0;
    m_t0  = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    ready = 1'b0;
    model_reset();
    #1;
    chk("reset_valid",    valid,    0);
    chk("reset_busy",     busy,     0);
    chk("reset_elapsed",  elapsed,  0);
    chk("reset_overflow", overflow, 0);
    #12;
    reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Table-driven basic measurement.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].s, tbl[i].p, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i),    valid,    tbl[i].ev);
      chk($sformatf("tbl%0d_busy", i),     busy,     tbl[i].eb);
      chk($sformatf("tbl%0d_elapsed", i),  elapsed,  tbl[i].eel);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eov);
    end

    // Saturation: N=20 saturates, N=15 fits exactly.
    cycle(1'b1, 1'b0, 1'b1);
    repeat (19) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("sat20_valid", valid, 1);
    chk("sat20_elapsed", elapsed, 15);
    chk("sat20_overflow", overflow, 1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (14) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("sat15_elapsed", elapsed, 15);
    chk("sat15_overflow", overflow, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Stop high through start (also start+edge in idle), low 1, high again.
    cycle(1'b1, 1'b1, 1'b1);
    chk("idle_sim_busy", busy, 1);
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    chk("level_no_capture", valid, 0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("level_valid", valid, 1);
    chk("level_elapsed", elapsed, 8);
    cycle(1'b0, 1'b0, 1'b1);

    // Restart 3 cycles into counting; measure from the second start.
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("restart_elapsed", elapsed, 4);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-pressure: result holds for 8 cycles despite start/stop pulses.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle((i % 3) == 0, (i % 2) == 1, 1'b0);
      chk("bp_valid", valid, 1);
      chk("bp_elapsed", elapsed, 6);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_release", valid, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Start together with a stop edge while counting: capture wins.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("cnt_sim_valid", valid, 1);
    chk("cnt_sim_busy", busy, 0);
    chk("cnt_sim_elapsed", elapsed, 2);
    cycle(1'b0, 1'b0, 1'b1);

    // Async reset while counting, then a clean measurement.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    async_reset("rst_cnt");
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("post_rst_elapsed", elapsed, 3);
    cycle(1'b0, 1'b0, 1'b1);

    // Async reset while a result is pending.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("pre_rst_done_valid", valid, 1);
    async_reset("rst_done");
    cycle(1'b0, 1'b0, 1'b1);
    chk("post_rst_done_valid", valid, 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      bit s;
      bit p;
      bit r;
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 7) == 0) ? ~stop : stop;
      r = ($urandom_range(0, 2) != 0);
      cycle(s, p, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
